// File: rtl/pool_window_reader_if.sv
// pool_window_reader_if
//   Result stream from the pooling read sequencer to its consumer.
//   Signals:
//     out_data  [data_width-1:0]  pooled value of the current window
//     out_idx   [1:0]             window index (0=TL, 1=TR, 2=BL, 3=BR)
//     out_valid                   out_data/out_idx are meaningful
//     out_ready                   consumer can take the current beat
//   Handshake: a beat transfers on a rising clk edge where out_valid and
//   out_ready are both high. Once out_valid rises it stays high, and
//   out_data/out_idx stay constant, until that transfer happens. out_ready
//   may be driven independently of out_valid.
//   Modports: master = producer (pool_window_reader), slave = consumer.
interface pool_window_reader_if #(
   parameter int data_width = 8
);
   logic [data_width-1:0] out_data;
   logic [1:0]            out_idx;
   logic                  out_valid;
   logic                  out_ready;

   modport master (output out_data, output out_idx, output out_valid,
                   input  out_ready);
   modport slave  (input  out_data, input  out_idx, input  out_valid,
                   output out_ready);
endinterface

// File: rtl/pool_window_reader.sv
// pool_window_reader
//   Read-side sequencer for the 16-entry pooling register file. The file is
//   viewed as a 4x4 row-major tile (address = row*4 + col). The four
//   non-overlapping 2x2 windows are read one entry per cycle through the
//   file's combinational read port, reduced to one value each, and
//   streamed out over a valid/ready handshake.
//   Optional feature macro: POOL_AVG_EN. When defined, an avg_mode input
//   selects average pooling (sum of the window >> 2) instead of max pooling.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     start      one-cycle request to pool the tile, sampled only in IDLE
//     avg_mode   (POOL_AVG_EN only) sampled with start, held for the tile
//     rd_addr    register file read address
//     rd_data    register file read data, same cycle as rd_addr
//     out        result stream (pool_window_reader_if master)
//     busy       high while not IDLE; the writer must not touch the tile
//     done       one-cycle pulse after window 3 is accepted
//     state_dbg  current FSM state
module pool_window_reader #(
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef POOL_AVG_EN
   input  logic                  avg_mode,
`endif
   output logic [3:0]            rd_addr,
   input  logic [data_width-1:0] rd_data,
   pool_window_reader_if.master  out,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            state_dbg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

`ifdef POOL_AVG_EN
   // Two extra bits hold the sum of four full-scale entries.
   localparam int acc_width = data_width + 2;
`else
   localparam int acc_width = data_width;
`endif

   logic [1:0]           state;
   logic [1:0]           win;
   logic [1:0]           beat;
   logic [acc_width-1:0] acc;
   logic [acc_width-1:0] acc_next;
   logic [acc_width-1:0] rd_ext;

`ifdef POOL_AVG_EN
   logic                 avg_q;
`endif

   assign rd_ext = acc_width'(rd_data);

   // Window origin is (2*win[1], 2*win[0]); beat[1] is the row offset and
   // beat[0] the column offset, so the address is just the bits interleaved.
   // win/beat are left untouched outside READ, which keeps rd_addr at its
   // last value there (beat parks at 3 when leaving READ).
   assign rd_addr = {win[1], beat[1], win[0], beat[0]};

   always_comb begin
      acc_next = acc;
      if (beat == 2'd0)
         acc_next = rd_ext;
`ifdef POOL_AVG_EN
      else if (avg_q)
         acc_next = acc + rd_ext;
`endif
      else if (rd_ext > acc)
         acc_next = rd_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         win   <= 2'd0;
         beat  <= 2'd0;
         acc   <= '0;
`ifdef POOL_AVG_EN
         avg_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= READ;
                  win   <= 2'd0;
                  beat  <= 2'd0;
`ifdef POOL_AVG_EN
                  avg_q <= avg_mode;
`endif
               end
            end
            READ: begin
               acc <= acc_next;
               if (beat == 2'd3)
                  state <= OUT;
               else
                  beat <= beat + 2'd1;
            end
            OUT: begin
               if (out.out_ready) begin
                  if (win == 2'd3) begin
                     state <= DONE;
                  end else begin
                     win   <= win + 2'd1;
                     beat  <= 2'd0;
                     state <= READ;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef POOL_AVG_EN
   // Average truncates toward zero: plain right shift of the unsigned sum.
   assign out.out_data = avg_q ? data_width'(acc >> 2) : acc[data_width-1:0];
`else
   assign out.out_data = acc;
`endif
   assign out.out_idx   = win;
   assign out.out_valid = (state == OUT);
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign state_dbg     = state;

endmodule

// File: tb/tb_pool_window_reader.sv
// tb_pool_window_reader
//   Bench for pool_window_reader. A behavioural tile memory answers reads;
//   each run logs every cycle's outputs, and each test compares the log
//   against expectations derived from the tile contents.
module tb_pool_window_reader;
   localparam int W = 8;
   localparam int N = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         out_ready;
   logic         avg_mode;
   logic [3:0]   rd_addr;
   logic [W-1:0] rd_data;
   logic         busy;
   logic         done;
   logic [1:0]   state_dbg;
   logic [W-1:0] mem [16];

   pool_window_reader_if #(.data_width(W)) pif ();
   assign pif.out_ready = out_ready;
   assign rd_data = mem[rd_addr];

   pool_window_reader #(.data_width(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
`ifdef POOL_AVG_EN
      .avg_mode  (avg_mode),
`endif
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out       (pif),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // per-cycle log of one run
   logic         log_valid [N];
   logic         log_ready [N];
   logic         log_done  [N];
   logic         log_busy  [N];
   logic [1:0]   log_idx   [N];
   logic [W-1:0] log_data  [N];
   logic [3:0]   log_addr  [N];

   // scoreboard
   logic [W-1:0] exp_q [$];
   logic [W-1:0] got_data [$];
   logic [1:0]   got_idx [$];
   int           got_cyc [$];
   int           done_cyc [$];

   // Reference: pool window w of the current tile with plain arithmetic.
   function automatic logic [W-1:0] ref_pool(input int w, input logic avg);
      int r0 = 2 * (w / 2);
      int c0 = 2 * (w % 2);
      int mx = 0;
      int sum = 0;
      int v;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            v = int'(mem[(r0 + dr) * 4 + c0 + dc]);
            sum += v;
            if (v > mx) mx = v;
         end
      return avg ? W'(sum / 4) : W'(mx);
   endfunction

   task automatic build_exp();
      exp_q.delete();
      for (int w = 0; w < 4; w++) exp_q.push_back(ref_pool(w, avg_mode));
   endtask

   // Called just after a rising edge; cycle c spans edge c-1 .. edge c.
   task automatic run_cycles(input int n, input int st_a, input int st_b,
                             input int st_c, input int rst_c,
                             input int stall_c, input int stall_n,
                             input logic rnd);
      for (int c = 0; c < n; c++) begin
         start = (c == st_a) || (c == st_b) || (c == st_c);
         rst   = (c == rst_c);
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         else     out_ready = !(stall_c >= 0 && c >= stall_c && c < stall_c + stall_n);
         @(negedge clk);
         log_valid[c] = pif.out_valid;
         log_ready[c] = out_ready;
         log_done[c]  = done;
         log_busy[c]  = busy;
         log_idx[c]   = pif.out_idx;
         log_data[c]  = pif.out_data;
         log_addr[c]  = rd_addr;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      rst   = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic collect(input int lo, input int hi);
      got_data.delete(); got_idx.delete(); got_cyc.delete(); done_cyc.delete();
      for (int c = lo; c <= hi; c++) begin
         if (log_valid[c] && log_ready[c]) begin
            got_data.push_back(log_data[c]);
            got_idx.push_back(log_idx[c]);
            got_cyc.push_back(c);
         end
         if (log_done[c]) done_cyc.push_back(c);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b1; avg_mode = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = W'(i);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rd_addr !== 4'd0 || pif.out_data !== 8'd0 || pif.out_idx !== 2'd0 ||
          pif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values got addr=%0d data=%0d idx=%0d valid=%b busy=%b done=%b want all 0",
                  rd_addr, pif.out_data, pif.out_idx, pif.out_valid, busy, done);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int exp_addr [$];
      int got_addr [$];
      int bad_busy = 0;
      for (int i = 0; i < 16; i++) mem[i] = W'(i);
      run_cycles(30, 0, -1, -1, -1, -1, 0, 1'b0);
      collect(0, 29);
      exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
      n_tests++;
      if (got_data.size() != 4) begin
         n_fail++; $display("FAIL basic_count got %0d want 4", got_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         n_tests++;
         if (got_data[k] !== exp_q[k] || got_idx[k] !== 2'(k) || got_cyc[k] != 5 + 5 * k) begin
            n_fail++;
            $display("FAIL basic_out%0d got data=%0d idx=%0d cyc=%0d want data=%0d idx=%0d cyc=%0d",
                     k, got_data[k], got_idx[k], got_cyc[k], exp_q[k], k, 5 + 5 * k);
         end
      end
      n_tests++;
      if (done_cyc.size() != 1 || done_cyc[0] != 21) begin
         n_fail++;
         $display("FAIL basic_done got count=%0d first=%0d want count=1 at 21",
                  done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      for (int c = 0; c < 30; c++)
         if (log_busy[c] !== (c >= 1 && c <= 21)) bad_busy++;
      n_tests++;
      if (bad_busy != 0) begin
         n_fail++; $display("FAIL basic_busy got %0d wrong cycles want 0", bad_busy);
      end
      for (int w = 0; w < 4; w++)
         for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
               exp_addr.push_back((2 * (w / 2) + dr) * 4 + 2 * (w % 2) + dc);
      for (int c = 0; c < 30; c++)
         if (log_busy[c] && !log_valid[c] && !log_done[c]) got_addr.push_back(int'(log_addr[c]));
      n_tests++;
      if (got_addr != exp_addr) begin
         n_fail++;
         $display("FAIL basic_addr_seq got %p want %p", got_addr, exp_addr);
      end
      n_tests++;
      if (log_addr[25] !== 4'd15) begin
         n_fail++; $display("FAIL basic_addr_hold got %0d want 15", log_addr[25]);
      end
   endtask

   task automatic test_stall();
      int bad_hold = 0;
      int exp_c [4] = '{5, 13, 18, 23};
      for (int i = 0; i < 16; i++) mem[i] = W'(i);
      run_cycles(32, 0, -1, -1, -1, 10, 3, 1'b0);
      collect(0, 31);
      exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
      for (int c = 10; c < 13; c++)
         if (log_valid[c] !== 1'b1 || log_idx[c] !== 2'd1 || log_data[c] !== 8'd7 ||
             log_addr[c] !== 4'd7) bad_hold++;
      n_tests++;
      if (bad_hold != 0) begin
         n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad_hold);
      end
      n_tests++;
      if (got_data.size() != 4) begin
         n_fail++; $display("FAIL stall_count got %0d want 4", got_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         n_tests++;
         if (got_data[k] !== exp_q[k] || got_idx[k] !== 2'(k) || got_cyc[k] != exp_c[k]) begin
            n_fail++;
            $display("FAIL stall_out%0d got data=%0d idx=%0d cyc=%0d want data=%0d idx=%0d cyc=%0d",
                     k, got_data[k], got_idx[k], got_cyc[k], exp_q[k], k, exp_c[k]);
         end
      end
      n_tests++;
      if (done_cyc.size() != 1 || done_cyc[0] != 24) begin
         n_fail++; $display("FAIL stall_done got count=%0d want count=1 at 24", done_cyc.size());
      end
   endtask

   task automatic test_edge_values();
      for (int i = 0; i < 16; i++) mem[i] = 8'd255;
      mem[0] = 8'd0;
      run_cycles(26, 0, -1, -1, -1, -1, 0, 1'b0);
      collect(0, 25);
      n_tests++;
      if (got_data.size() != 4 || done_cyc.size() != 1) begin
         n_fail++;
         $display("FAIL edge_count got outs=%0d dones=%0d want 4 and 1", got_data.size(), done_cyc.size());
      end
      for (int k = 0; k < got_data.size(); k++) begin
         n_tests++;
         if (got_data[k] !== 8'd255) begin
            n_fail++; $display("FAIL edge_out%0d got %0d want 255", k, got_data[k]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int first_outs = 0;
      int exp_c2 [4] = '{27, 32, 37, 42};
      for (int i = 0; i < 16; i++) mem[i] = W'(i);
      run_cycles(48, 0, 3, 21, -1, -1, 0, 1'b0);
      // the third pulse at 21 lands in DONE; a fresh pulse at 22 restarts
      run_cycles(0, -1, -1, -1, -1, -1, 0, 1'b0);
      collect(0, 47);
      for (int k = 0; k < got_cyc.size(); k++) if (got_cyc[k] <= 21) first_outs++;
      n_tests++;
      if (first_outs != 4 || got_data.size() != 4 || done_cyc.size() != 1 || done_cyc[0] != 21) begin
         n_fail++;
         $display("FAIL start_ignored got outs=%0d/%0d dones=%0d want 4/4 and one done at 21",
                  first_outs, got_data.size(), done_cyc.size());
      end
      n_tests++;
      if (log_busy[22] !== 1'b0 || log_busy[23] !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done got busy22=%b busy23=%b want 0 0", log_busy[22], log_busy[23]);
      end
      // now a real restart from IDLE at cycle 22
      run_cycles(46, -1, -1, 22, -1, -1, 0, 1'b0);
      collect(0, 45);
      n_tests++;
      if (got_data.size() != 4 || done_cyc.size() != 1 || done_cyc[0] != 43) begin
         n_fail++;
         $display("FAIL restart got outs=%0d dones=%0d want 4 and one done at 43",
                  got_data.size(), done_cyc.size());
      end
      for (int k = 0; k < 4 && k < got_cyc.size(); k++) begin
         n_tests++;
         if (got_cyc[k] != exp_c2[k] || got_data[k] !== ref_pool(k, 1'b0)) begin
            n_fail++;
            $display("FAIL restart_out%0d got data=%0d cyc=%0d want data=%0d cyc=%0d",
                     k, got_data[k], got_cyc[k], ref_pool(k, 1'b0), exp_c2[k]);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 16; i++) mem[i] = W'(i);
      run_cycles(34, 0, 10, -1, 8, -1, 0, 1'b0);
      n_tests++;
      if (log_addr[9] !== 4'd0 || log_data[9] !== 8'd0 || log_idx[9] !== 2'd0 ||
          log_valid[9] !== 1'b0 || log_busy[9] !== 1'b0 || log_done[9] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_values got addr=%0d data=%0d idx=%0d valid=%b busy=%b done=%b want all 0",
                  log_addr[9], log_data[9], log_idx[9], log_valid[9], log_busy[9], log_done[9]);
      end
      collect(0, 33);
      n_tests++;
      if (done_cyc.size() != 1 || done_cyc[0] != 31) begin
         n_fail++; $display("FAIL midrst_done got count=%0d want count=1 at 31", done_cyc.size());
      end
      collect(10, 33);
      n_tests++;
      if (got_data.size() != 4) begin
         n_fail++; $display("FAIL midrst_count got %0d want 4", got_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         n_tests++;
         if (got_data[k] !== ref_pool(k, 1'b0) || got_idx[k] !== 2'(k) || got_cyc[k] != 15 + 5 * k) begin
            n_fail++;
            $display("FAIL midrst_out%0d got data=%0d idx=%0d cyc=%0d want data=%0d idx=%0d cyc=%0d",
                     k, got_data[k], got_idx[k], got_cyc[k], ref_pool(k, 1'b0), k, 15 + 5 * k);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 16; i++) mem[i] = W'($urandom_range(0, 255));
`ifdef POOL_AVG_EN
         avg_mode = 1'($urandom_range(0, 1));
`endif
         build_exp();
         run_cycles(100, 0, -1, -1, -1, -1, 0, 1'b1);
         collect(0, 99);
         n_tests++;
         if (got_data.size() != 4 || done_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL rand%0d_count got outs=%0d dones=%0d want 4 and 1", t, got_data.size(), done_cyc.size());
         end
         for (int k = 0; k < 4 && k < got_data.size(); k++) begin
            n_tests++;
            if (got_data[k] !== exp_q[k] || got_idx[k] !== 2'(k)) begin
               n_fail++;
               $display("FAIL rand%0d_out%0d got data=%0d idx=%0d want data=%0d idx=%0d",
                        t, k, got_data[k], got_idx[k], exp_q[k], k);
            end
         end
      end
      avg_mode = 1'b0;
   endtask

`ifdef POOL_AVG_EN
   task automatic test_avg();
      logic [W-1:0] exp_a [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
      avg_mode = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = W'(i);
      run_cycles(26, 0, -1, -1, -1, -1, 0, 1'b0);
      collect(0, 25);
      n_tests++;
      if (got_data.size() != 4) begin
         n_fail++; $display("FAIL avg_count got %0d want 4", got_data.size());
      end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         n_tests++;
         if (got_data[k] !== exp_a[k]) begin
            n_fail++; $display("FAIL avg_out%0d got %0d want %0d", k, got_data[k], exp_a[k]);
         end
      end
      for (int i = 0; i < 16; i++) mem[i] = 8'd255;
      run_cycles(26, 0, -1, -1, -1, -1, 0, 1'b0);
      collect(0, 25);
      n_tests++;
      if (got_data.size() != 4) begin
         n_fail++; $display("FAIL avg_full_count got %0d want 4", got_data.size());
      end
      for (int k = 0; k < got_data.size(); k++) begin
         n_tests++;
         if (got_data[k] !== 8'd255) begin
            n_fail++; $display("FAIL avg_full_out%0d got %0d want 255", k, got_data[k]);
         end
      end
      avg_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_edge_values();
      test_start_ignored();
      test_mid_reset();
`ifdef POOL_AVG_EN
      test_avg();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pool_window_reader.md
Name: pool_window_reader

Overview:
- Read-side sequencer for the 16-entry pooling register file.
- Treats the 16 entries as a 4x4 tile, row-major (address = row*4 + col).
- Walks the four non-overlapping 2x2 windows through the file's combinational read port and reduces each window to one value (max pooling).
- Streams the four results downstream over a valid/ready handshake; busy tells the writer side to hold off writes.

Parameters:
- data_width, 8, bit width of register-file entries and of pooled results.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to pool the current tile; sampled only in IDLE.
- rd_addr  output  4  read address to register file read port (add_out).
- rd_data  input  data_width  register file read data; combinational from rd_addr, same cycle.
- out_data  output  data_width  pooled value of current window.
- out_idx  output  2  window index 0..3 (0=TL, 1=TR, 2=BL, 3=BR quadrant).
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- busy  output  1  high whenever state != IDLE; writer must not write the tile while high.
- done  output  1  one-cycle pulse after window 3 is accepted.

Behaviour:
- Reset (rst high at a clock edge) gives state IDLE and win=0, beat=0, acc=0.
- Reset outputs: rd_addr=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0.
- Reset overrides everything, including mid-operation; the in-flight tile is abandoned and no done is produced.
- States: IDLE, READ, OUT, DONE.
- IDLE: on start=1, go to READ with win=0, beat=0. Otherwise stay.
- READ: 4 cycles per window, beat 0..3.
  - Window origin: r0 = 2*win[1], c0 = 2*win[0].
  - Beat order: TL (r0,c0), TR (r0,c0+1), BL (r0+1,c0), BR (r0+1,c0+1).
  - rd_addr = (r0+dr)*4 + (c0+dc), driven from registered state.
  - Beat 0: acc <= rd_data. Beats 1-3: acc <= max(acc, rd_data), unsigned compare; on a tie acc is unchanged.
  - After beat 3, go to OUT.
- OUT:
  - out_valid=1, out_data=acc, out_idx=win.
  - out_data, out_idx and rd_addr stay stable while out_ready=0, with no timeout.
  - On out_valid and out_ready: if win==3 go to DONE; else win <= win+1, beat <= 0, go to READ.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in DONE.
- rd_addr outside READ holds its last value; after reset it is 0.
- start is ignored while busy, with no queuing. start in the DONE cycle is also ignored.
- Latency with out_ready held high and start at cycle 0:
  - READ cycles 1-4, first out_valid at cycle 5.
  - Each window takes 5 cycles; window 3 valid at cycle 20.
  - done at cycle 21; busy high cycles 1-21.
- Each stall cycle with out_ready=0 adds exactly one cycle.
- Tile contents must be stable from start until done. The block does not check this.

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined: adds input port avg_mode (1 bit).
  - avg_mode is sampled with start and held for the whole tile.
  - avg_mode=1: acc becomes a (data_width+2)-bit sum. out_data = sum >> 2, truncating toward zero, with no rounding.
  - avg_mode=0: max pooling exactly as above.
- Not defined: the avg_mode port does not exist; max pooling only; no extra sum-width logic.

Test Plan:
- Tile entry i = i, start, out_ready=1 -> outputs (idx,data) = (0,5), (1,7), (2,13), (3,15) at cycles 5, 10, 15, 20; done at cycle 21; rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
- Same tile, out_ready low for 3 cycles when window 1 becomes valid -> out_data=7 and out_idx=1 held stable for those 3 cycles; done at cycle 24; no duplicate or dropped outputs.
- All entries 255, except entry 0 = 0 -> outputs 255,255,255,255; unsigned compare and tie handling correct.
- start pulsed again at cycles 3 and 21 -> ignored, exactly 4 outputs and one done; start at cycle 22 -> new run begins.
- rst asserted at cycle 8 (mid window 1) -> next cycle all outputs at reset values, busy=0, no done; a fresh start then produces the full correct 4-output sequence.
- POOL_AVG_EN defined, avg_mode=1, tile entry i = i -> outputs 2, 4, 10, 12; all entries 255 -> 255 each (no overflow).
